// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: the page-table walker (port 0) and the memory stage (port 1)
// share one data-bus port, one captured transaction at a time, round-robin or fixed priority.
package dbus_pkg;
   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  dbus_req_t        req0,
   output dbus_resp_t       resp0,
   input  dbus_req_t        req1,
   output dbus_resp_t       resp1,
   output dbus_req_t        dreq,
   input  dbus_resp_t       dresp,
   output logic             busy,
   output logic             owner,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
   output logic [1:0]       state_dbg
);

   // Handshake: a requester holds valid and its fields until its response arrives
   // (addr_ok & data_ok in one cycle while granted); the bus sees only the captured copy.
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;

   state_t    state, next_state;
   logic      last_gnt;
   dbus_req_t hold;
   logic      do_grant;
   logic      win;
   logic      done;

   assign done      = (state == GRANT) && dresp.addr_ok && dresp.data_ok;
   assign state_dbg = state;

   always_comb begin
      next_state = state;
      do_grant   = 1'b0;
      win        = 1'b0;
      case (state)
         IDLE: begin
            if (req0.valid || req1.valid) begin
               do_grant   = 1'b1;
               next_state = GRANT;
               if (req0.valid && req1.valid) win = FIXED_PRIO ? 1'b0 : ~last_gnt;
               else                          win = req1.valid;
            end
         end
         GRANT:   if (done) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         hold     <= '0;
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         state <= next_state;
         if (do_grant) begin
            owner      <= win;
            last_gnt   <= win;
            hold       <= win ? req1 : req0;
            hold.valid <= 1'b0;
            if (win) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            else     gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
         end
      end
   end

   // Bus request depends only on registers; responses are steered combinationally.
   always_comb begin
      dreq = '0;
      if (state == GRANT) begin
         dreq       = hold;
         dreq.valid = 1'b1;
      end
   end

   assign resp0 = (done && !owner) ? dresp : '0;
   assign resp1 = (done &&  owner) ? dresp : '0;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: one round-robin instance and one fixed-priority
// instance with 2-bit grant counters so counter wrap can be observed.
module tb_dbus_arbiter;
   import dbus_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dbus_req_t  req0, req1, dreq, req0_f, req1_f, dreq_f;
   dbus_resp_t resp0, resp1, dresp, resp0_f, resp1_f, dresp_f;
   logic        busy, owner, busy_f, owner_f;
   logic [31:0] gnt_cnt0, gnt_cnt1;
   logic [1:0]  gnt_cnt0_f, gnt_cnt1_f;
   logic [1:0]  state_dbg, state_dbg_f;

   dbus_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .resp0(resp0), .req1(req1), .resp1(resp1),
      .dreq(dreq), .dresp(dresp), .busy(busy), .owner(owner),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .state_dbg(state_dbg));

   dbus_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(2)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req0(req0_f), .resp0(resp0_f), .req1(req1_f), .resp1(resp1_f),
      .dreq(dreq_f), .dresp(dresp_f), .busy(busy_f), .owner(owner_f),
      .gnt_cnt0(gnt_cnt0_f), .gnt_cnt1(gnt_cnt1_f), .state_dbg(state_dbg_f));

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      req0    = '0; req1   = '0; dresp   = '0;
      req0_f  = '0; req1_f = '0; dresp_f = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Starts in IDLE at a negedge with requests already driven; ends back in IDLE.
   task automatic tie_txn(input bit fp, input logic exp_owner, input string tag);
      tick();
      check({tag, "_owner"}, fp ? owner_f : owner, exp_owner);
      check({tag, "_dreq_valid"}, fp ? dreq_f.valid : dreq.valid, 1'b1);
      if (fp) dresp_f = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hA5A5_0000_0000_5A5A};
      else    dresp   = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hA5A5_0000_0000_5A5A};
      #1;
      if (fp) check({tag, "_resp"}, exp_owner ? resp1_f.data : resp0_f.data, 64'hA5A5_0000_0000_5A5A);
      else    check({tag, "_resp"}, exp_owner ? resp1.data : resp0.data, 64'hA5A5_0000_0000_5A5A);
      tick();
      dresp   = '0;
      dresp_f = '0;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      check("rst_busy", busy, 1'b0);
      check("rst_owner", owner, 1'b0);
      check("rst_dreq", dreq, '0);
      check("rst_cnt0", gnt_cnt0, 0);
      check("rst_cnt1", gnt_cnt1, 0);
      check("rst_state", state_dbg, 2'd0);

      // Single port 1 read, bus answers on the third granted cycle
      req1 = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      tick();
      check("rd_dreq_valid", dreq.valid, 1'b1);
      check("rd_dreq_addr", dreq.addr, 32'h8000_0010);
      check("rd_dreq_size", dreq.size, MSIZE8);
      check("rd_dreq_strobe", dreq.strobe, 8'h00);
      check("rd_owner", owner, 1'b1);
      check("rd_cnt1", gnt_cnt1, 1);
      tick();
      check("rd_wait_resp1", resp1, '0);
      tick();
      dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1122_3344_5566_7788};
      #1;
      check("rd_resp1_data", resp1.data, 64'h1122_3344_5566_7788);
      check("rd_resp0_zero", resp0, '0);
      req1 = '0;
      tick();
      dresp = '0;
      check("rd_done_valid", dreq.valid, 1'b0);
      check("rd_done_busy", busy, 1'b1);
      tick();
      check("rd_idle_busy", busy, 1'b0);

      // Round-robin tie stream
      do_reset();
      req0 = '{valid: 1'b1, addr: 32'h0000_1000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      req1 = '{valid: 1'b1, addr: 32'h0000_2000, size: MSIZE4, strobe: 8'hFF, data: 64'h77};
      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      while (exp_q.size() > 0) tie_txn(1'b0, exp_q.pop_front(), "rr");
      check("rr_cnt0", gnt_cnt0, 2);
      check("rr_cnt1", gnt_cnt1, 2);
      req0 = '0;
      req1 = '0;

      // Fixed-priority tie stream, 2-bit counters wrap after four port-0 grants
      req0_f = '{valid: 1'b1, addr: 32'h0000_3000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      req1_f = '{valid: 1'b1, addr: 32'h0000_4000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      for (int i = 0; i < 4; i++) tie_txn(1'b1, 1'b0, "fp");
      check("fp_cnt0_wrap", gnt_cnt0_f, 2'd0);
      check("fp_cnt1", gnt_cnt1_f, 2'd0);
      req0_f.valid = 1'b0;
      tie_txn(1'b1, 1'b1, "fp_solo1");
      check("fp_cnt1_after", gnt_cnt1_f, 2'd1);
      req0_f.valid = 1'b1;
      req1_f.valid = 1'b0;
      tie_txn(1'b1, 1'b0, "fp_solo0");
      check("fp_cnt0_after", gnt_cnt0_f, 2'd1);
      req0_f = '0;

      // Requester drops valid and changes fields after the grant
      do_reset();
      req1 = '{valid: 1'b1, addr: 32'h0000_0100, size: MSIZE4, strobe: 8'h0F, data: 64'hDEAD_BEEF};
      tick();
      req1 = '{valid: 1'b0, addr: 32'h0000_0200, size: MSIZE1, strobe: 8'h01, data: 64'h0};
      tick();
      check("drop_addr", dreq.addr, 32'h0000_0100);
      check("drop_strobe", dreq.strobe, 8'h0F);
      check("drop_data", dreq.data, 64'hDEAD_BEEF);
      check("drop_valid", dreq.valid, 1'b1);
      dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
      #1;
      check("drop_resp1_ok", resp1.data_ok, 1'b1);
      tick();
      dresp = '0;
      check("drop_done_state", state_dbg, 2'd2);
      tick();
      check("drop_idle_state", state_dbg, 2'd0);
      tick();
      check("drop_stay_idle", busy, 1'b0);

      // Split handshake: addr_ok alone does not complete
      do_reset();
      req0 = '{valid: 1'b1, addr: 32'h0000_0040, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      tick();
      dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 64'h0};
      #1;
      check("split_resp0_zero_a", resp0, '0);
      tick();
      #1;
      check("split_resp0_zero_b", resp0, '0);
      check("split_still_grant", dreq.valid, 1'b1);
      tick();
      dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFE};
      #1;
      check("split_resp0_data", resp0.data, 64'hCAFE);
      check("split_resp0_ok", resp0.data_ok, 1'b1);
      req0 = '0;
      tick();
      dresp = '0;
      check("split_done_valid", dreq.valid, 1'b0);
      tick();

      // Reset while granted
      do_reset();
      req0 = '{valid: 1'b1, addr: 32'h0000_0080, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      tick();
      check("rstmid_pre_valid", dreq.valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", dreq.valid, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_cnt0", gnt_cnt0, 0);
      req0 = '0;
      tick();
      rst_n = 1'b1;
      req1 = '{valid: 1'b1, addr: 32'h0000_00C0, size: MSIZE2, strobe: 8'h03, data: 64'h1234};
      tick();
      check("rstmid_new_owner", owner, 1'b1);
      check("rstmid_new_addr", dreq.addr, 32'h0000_00C0);
      check("rstmid_new_cnt1", gnt_cnt1, 1);
      req1 = '0;
      dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
      tick();
      dresp = '0;
      tick();

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
